// File: rtl/uart_rx_buffer_pkg.sv
// Shared flow-control characters and FSM state encoding for the UART receive buffer.
package uart_rx_buffer_pkg;

    localparam logic [7:0] XON_CHAR  = 8'h11;
    localparam logic [7:0] XOFF_CHAR = 8'h13;

    typedef enum logic [2:0] {
        IDLE,
        SEND_XOFF,
        WAIT_XOFF,
        PAUSED,
        SEND_XON,
        WAIT_XON
    } FlowState_t;

endpackage

// File: rtl/uart_rx_buffer_fifo.sv
// byte_fifo_core: first-word fall-through byte FIFO with push/pop/drop rules.
// A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module byte_fifo_core #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_push,
    input  logic [7:0]                   i_data,
    input  logic                         i_ready,
    output logic                         o_valid,
    output logic [7:0]                   o_data,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_write;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_pop   = !w_empty && i_ready;
    assign w_write = i_push && (!w_full || w_pop);
    assign o_drop  = i_push && w_full && !w_pop;

    assign o_valid = !w_empty;
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage write; contents need no reset since head is qualified by o_valid.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: elastic receive buffer with sticky overflow flag and XON/XOFF flow control.
module uart_rx_buffer
    import uart_rx_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned XOFF_LEVEL = 12,
    parameter int unsigned XON_LEVEL  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         inValid,
    input  logic [7:0]                   inData,
    output logic                         outValid,
    output logic [7:0]                   outData,
    input  logic                         outReady,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    input  logic                         overflowClear,
    output logic                         txStart,
    output logic [7:0]                   txData,
    input  logic                         txBusy,
    output logic                         paused
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] L_XOFF = CW'(XOFF_LEVEL);
    localparam logic [CW-1:0] L_XON  = CW'(XON_LEVEL);

    logic w_drop;

    FlowState_t r_state;
    FlowState_t w_next_state;
    logic       r_txStart;
    logic       w_next_txStart;
    logic [7:0] r_txData;
    logic [7:0] w_next_txData;
    logic       r_paused;
    logic       w_next_paused;
    logic       r_overflow;

    byte_fifo_core #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (inValid),
        .i_data  (inData),
        .i_ready (outReady),
        .o_valid (outValid),
        .o_data  (outData),
        .o_count (count),
        .o_drop  (w_drop)
    );

    // Sticky overflow flag; a new drop takes priority over a clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (overflowClear) begin
            r_overflow <= 1'b0;
        end
    end

    // Flow-control state and registered transmitter request outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_txStart <= 1'b0;
            r_txData  <= 8'h00;
            r_paused  <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_txStart <= w_next_txStart;
            r_txData  <= w_next_txData;
            r_paused  <= w_next_paused;
        end
    end

    // Next-state logic; in WAIT states the cycle with txStart still high is the
    // one-cycle gap before the transmitter raises busy, so completion is ignored there.
    always_comb begin
        w_next_state   = r_state;
        w_next_txStart = 1'b0;
        w_next_txData  = r_txData;
        w_next_paused  = r_paused;
        case (r_state)
            IDLE: begin
                if (count >= L_XOFF) begin
                    w_next_state  = SEND_XOFF;
                    w_next_paused = 1'b1;
                end
            end
            SEND_XOFF: begin
                if (!txBusy) begin
                    w_next_txStart = 1'b1;
                    w_next_txData  = XOFF_CHAR;
                    w_next_state   = WAIT_XOFF;
                end
            end
            WAIT_XOFF: begin
                if (!r_txStart && !txBusy) begin
                    w_next_state = PAUSED;
                end
            end
            PAUSED: begin
                if (count <= L_XON) begin
                    w_next_state = SEND_XON;
                end
            end
            SEND_XON: begin
                if (!txBusy) begin
                    w_next_txStart = 1'b1;
                    w_next_txData  = XON_CHAR;
                    w_next_paused  = 1'b0;
                    w_next_state   = WAIT_XON;
                end
            end
            WAIT_XON: begin
                if (!r_txStart && !txBusy) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign overflow = r_overflow;
    assign txStart  = r_txStart;
    assign txData   = r_txData;
    assign paused   = r_paused;

endmodule
